// File: rtl/bus_arbiter_if.sv
// bus: shared one-bit request/response bus. The primary side (responder) drives b,
// the secondary side (arbiter) drives a.
interface bus (
  input logic clk
);
  logic a;
  logic b;

  modport primary   (input clk, input a, output b);
  modport secondary (input clk, output a, input b);
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter that lets N requesters share one bus (secondary side).
// Define BUS_ARBITER_TIMEOUT_EN to force rotation after MAX_HOLD owned cycles when others wait.
module bus_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic [N-1:0] data,
  output logic [N-1:0] gnt,
  output logic [N-1:0] resp,
  bus.secondary        intf
);
  localparam int PTR_W = $clog2(N);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OWN  = 1'b1;

  generate
    if (N < 2 || N > 16) begin : g_bad_n
      $error("bus_arbiter: N must be in 2..16");
    end
    if (MAX_HOLD < 2) begin : g_bad_hold
      $error("bus_arbiter: MAX_HOLD must be at least 2");
    end
  endgenerate

  logic [0:0]       state_q, state_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     gnt_q, gnt_d;

  logic             found;
  logic [PTR_W-1:0] win;
  logic [PTR_W-1:0] ptr_next;
  logic             force_rel;

  // First set request in search order ptr, ptr+1, ... modulo N.
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default first so no path infers a latch.
    found    = 1'b0;
    win      = '0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && req[PTR_W'(idx)]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
    // Explicit wrap keeps the pointer legal when N is not a power of two.
    ptr_next = (win == PTR_W'(N - 1)) ? '0 : win + 1'b1;
  end

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD) + 1;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  always_comb begin
    hold_cnt_d = '0;
    if (state_q == OWN && state_d == OWN) begin
      hold_cnt_d = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1)) ? hold_cnt_q : hold_cnt_q + 1'b1;
    end
  end

  // Rotate only when someone else is actually waiting.
  assign force_rel = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1)) && (|(req & ~gnt_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_cnt_q <= '0;
    else        hold_cnt_q <= hold_cnt_d;
  end
`else
  assign force_rel = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = OWN;
          owner_d    = win;
          ptr_d      = ptr_next;
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
        end
      end
      default: begin
        // Every release goes through IDLE, giving a one-cycle turnaround bubble.
        if (!req[owner_q] || force_rel) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt    = gnt_q;
  assign intf.a = (state_q == OWN) ? data[owner_q] : 1'b0;
  assign resp   = gnt_q & {N{intf.b}};
endmodule
